// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin arbiter sharing one 1-second-tick countdown timer among three requesters
module timer_arbiter #(
    parameter int TICK_DIV = 40_000_000
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [7:0] dur0,
    input  logic [7:0] dur1,
    input  logic [7:0] dur2,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic       busy,
    output logic [7:0] remaining,
    output logic       sec_tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TOP = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [2:0] grant_nx;
    logic [7:0] remaining_nx, dur_win;
    logic [1:0] last_grant, last_nx, n1, n2, win, cur;
    logic cancel;

    assign n1 = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
    assign n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    assign win = req[n1] ? n1 : req[n2] ? n2 : last_grant;
    assign dur_win = (win == 2'd0) ? dur0 : (win == 2'd1) ? dur1 : dur2;
    assign cur = grant[2] ? 2'd2 : grant[1] ? 2'd1 : 2'd0;
    assign cancel = (req & grant) == 3'b000;
    assign sec_tick = (state == RUN) && (presc == TOP);
    assign done = (state == DONE) ? grant : 3'b000;
    assign busy = state != IDLE;

    // State and datapath registers; reset forces idle with req[0] first in line
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= 3'b000;
            remaining  <= 8'd0;
            presc      <= '0;
            last_grant <= 2'd2;
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            remaining  <= remaining_nx;
            presc      <= presc_nx;
            last_grant <= last_nx;
        end
    end

    // Next-state: arbitrate in IDLE, count down in RUN (cancel wins over expiry), release after DONE
    always_comb begin
        state_nx     = state;
        grant_nx     = grant;
        remaining_nx = remaining;
        presc_nx     = presc;
        last_nx      = last_grant;
        case (state)
            IDLE: if (|req) begin
                state_nx     = RUN;
                grant_nx     = 3'b001 << win;
                remaining_nx = dur_win;
                presc_nx     = '0;
            end
            RUN: if (cancel) begin
                state_nx     = IDLE;
                grant_nx     = 3'b000;
                remaining_nx = 8'd0;
                presc_nx     = '0;
                last_nx      = cur;
            end else if (remaining == 8'd0) begin
                state_nx = DONE;
            end else begin
                presc_nx = sec_tick ? '0 : presc + PW'(1);
                if (sec_tick) begin
                    remaining_nx = remaining - 8'd1;
                    state_nx     = (remaining == 8'd1) ? DONE : RUN;
                end
            end
            DONE: begin
                state_nx = IDLE;
                grant_nx = 3'b000;
                presc_nx = '0;
                last_nx  = cur;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
